updown_modn_counter: RTL and testbench

- Parametrised loadable up/down modulo-N counter; successor to the fixed mod-12 loadable counter.
- Adds:
  - generic width and modulus
  - count enable
  - wrap or saturate selection
  - correct wrap in both directions
  - registered wrap/terminal pulses for cascading
  - load range checking
- Used as a timing/sequence counter and as a cascadable digit stage in packet-length and timeout logic.

---
 rtl/counter_pkg.sv | 41 ++++
 rtl/updown_modn_counter_if.sv | 37 +++
 rtl/updown_modn_counter.sv | 100 ++++++++++
 tb/tb_updown_modn_counter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared counter helpers: direction encodings and the modulo-N next-value function,
// written at a fixed maximum width so counters of any WIDTH up to 32 bits can reuse it.
package counter_pkg;

    localparam logic COUNT_UP   = 1'b0;
    localparam logic COUNT_DOWN = 1'b1;

    localparam int unsigned ModnMaxWidth = 32;

    typedef logic [ModnMaxWidth:0] modn_val_t;

    typedef struct packed {
        modn_val_t value;
        logic      wrap;
    } modn_res_t;

    // One count step in the range 0..modulus-1; wrap flags a carry or borrow.
    function automatic modn_res_t modn_next(input modn_val_t value, input modn_val_t modulus,
                                            input logic mode, input logic sat);
        modn_res_t res;
        res.value = value;
        res.wrap  = 1'b0;
        if (mode == COUNT_DOWN) begin
            if (value != '0) begin
                res.value = value - modn_val_t'(1);
            end else if (!sat) begin
                res.value = modulus - modn_val_t'(1);
                res.wrap  = 1'b1;
            end
        end else begin
            if (value + modn_val_t'(1) < modulus) begin
                res.value = value + modn_val_t'(1);
            end else if (!sat) begin
                res.value = '0;
                res.wrap  = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/updown_modn_counter_if.sv
// Control and status bundle of the up/down modulo-N counter.
// UPDOWN_MODN_PROG_MOD_EN adds the runtime modulus write port (mod_we, mod_in).
interface updown_modn_counter_if #(
    parameter int unsigned WIDTH = 4
) ();

    logic             enable;
    logic             load;
    logic             mode;
    logic             sat;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             tc;
    logic             wrap;
    logic             load_err;
`ifdef UPDOWN_MODN_PROG_MOD_EN
    logic             mod_we;
    logic [WIDTH:0]   mod_in;
`endif

    modport master (
        output enable, load, mode, sat, data_in,
`ifdef UPDOWN_MODN_PROG_MOD_EN
        output mod_we, mod_in,
`endif
        input  data_out, tc, wrap, load_err
    );

    modport slave (
        input  enable, load, mode, sat, data_in,
`ifdef UPDOWN_MODN_PROG_MOD_EN
        input  mod_we, mod_in,
`endif
        output data_out, tc, wrap, load_err
    );

endinterface

// File: rtl/updown_modn_counter.sv
// Loadable up/down modulo-N counter with wrap/saturate, cascade pulses and load range check.
// Define UPDOWN_MODN_PROG_MOD_EN for a runtime-programmable modulus register.
module updown_modn_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MODULUS   = 12,
    parameter int unsigned RESET_VAL = 0
) (
    input logic                  clock,
    input logic                  reset,
    updown_modn_counter_if.slave bus
);

    typedef logic [WIDTH:0] ext_t;

    localparam ext_t ModConst = ext_t'(MODULUS);
    localparam ext_t One      = ext_t'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    ext_t             cur_mod;
    ext_t             count_ext;
    ext_t             mod_m1;
    modn_res_t        step;
    logic             unused_step_hi;

`ifdef UPDOWN_MODN_PROG_MOD_EN
    localparam ext_t MaxMod = {1'b1, {WIDTH{1'b0}}};
    localparam ext_t Two    = ext_t'(2);

    ext_t mod_q, mod_d;

    assign cur_mod = mod_q;
`else
    assign cur_mod = ModConst;
`endif

    // Widened by one bit so MODULUS = 2**WIDTH compares without overflow.
    assign count_ext = {1'b0, count_q};
    assign mod_m1    = cur_mod - One;

    assign step = modn_next(modn_val_t'(count_ext), modn_val_t'(cur_mod), bus.mode, bus.sat);
    assign unused_step_hi = ^step.value[ModnMaxWidth:WIDTH];

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
`ifdef UPDOWN_MODN_PROG_MOD_EN
        mod_d   = mod_q;
        if (bus.mod_we) begin
            if (bus.mod_in < Two || bus.mod_in > MaxMod) begin
                err_d = 1'b1;
            end else begin
                mod_d = bus.mod_in;
                if (count_ext >= bus.mod_in) begin
                    count_d = WIDTH'(bus.mod_in - One);
                end
            end
        end else
`endif
        if (bus.load) begin
            if ({1'b0, bus.data_in} < cur_mod) begin
                count_d = bus.data_in;
            end else begin
                count_d = WIDTH'(mod_m1);
                err_d   = 1'b1;
            end
        end else if (bus.enable) begin
            count_d = step.value[WIDTH-1:0];
            wrap_d  = step.wrap;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= WIDTH'(RESET_VAL);
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef UPDOWN_MODN_PROG_MOD_EN
            mod_q   <= ModConst;
`endif
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
`ifdef UPDOWN_MODN_PROG_MOD_EN
            mod_q   <= mod_d;
`endif
        end
    end

    assign bus.data_out = count_q;
    assign bus.wrap     = wrap_q;
    assign bus.load_err = err_q;
    assign bus.tc       = (bus.mode == COUNT_UP) ? (count_ext == mod_m1) : (count_q == '0);

endmodule

// File: tb/tb_updown_modn_counter.sv
// Bench for updown_modn_counter: a mod-12 and a mod-16 instance share stimulus and are
// checked against a behavioural model, plus vector tables and hand-written corner cases.
module tb_updown_modn_counter;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       load;
    logic       mode;
    logic       sat;
    logic [3:0] data_in;
    logic       mod_we;
    logic [4:0] mod_in;

    int unsigned total = 0;
    int unsigned bad   = 0;

    updown_modn_counter_if #(.WIDTH(4)) bus_a ();
    updown_modn_counter_if #(.WIDTH(4)) bus_b ();

    assign bus_a.enable  = enable;
    assign bus_a.load    = load;
    assign bus_a.mode    = mode;
    assign bus_a.sat     = sat;
    assign bus_a.data_in = data_in;
    assign bus_b.enable  = enable;
    assign bus_b.load    = load;
    assign bus_b.mode    = mode;
    assign bus_b.sat     = sat;
    assign bus_b.data_in = data_in;
`ifdef UPDOWN_MODN_PROG_MOD_EN
    assign bus_a.mod_we  = mod_we;
    assign bus_a.mod_in  = mod_in;
    assign bus_b.mod_we  = mod_we;
    assign bus_b.mod_in  = mod_in;
`endif

    updown_modn_counter #(.WIDTH(4), .MODULUS(12), .RESET_VAL(0)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );

    updown_modn_counter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(3)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural model, index 0 = dut_a, 1 = dut_b.
    int cfg_mod[2] = '{12, 16};
    int cfg_rst[2] = '{0, 3};
    int m_count[2];
    int m_mod[2];
    bit m_wrap[2];
    bit m_err[2];

    typedef struct {
        bit en;
        bit ld;
        bit md;
        bit st;
        int din;
        int out;
        bit wr;
        bit er;
        bit tcx;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_count[i] = cfg_rst[i];
            m_mod[i]   = cfg_mod[i];
            m_wrap[i]  = 1'b0;
            m_err[i]   = 1'b0;
        end
    endtask

    task automatic model_step(input int i);
        int m;
        m         = m_mod[i];
        m_wrap[i] = 1'b0;
        m_err[i]  = 1'b0;
        if (mod_we) begin
            if (int'(mod_in) < 2 || int'(mod_in) > 16) begin
                m_err[i] = 1'b1;
            end else begin
                m_mod[i] = int'(mod_in);
                if (m_count[i] >= m_mod[i]) m_count[i] = m_mod[i] - 1;
            end
        end else if (load) begin
            if (int'(data_in) < m) begin
                m_count[i] = int'(data_in);
            end else begin
                m_count[i] = m - 1;
                m_err[i]   = 1'b1;
            end
        end else if (enable) begin
            if (!mode) begin
                if (sat) m_count[i] = (m_count[i] + 1 > m - 1) ? m - 1 : m_count[i] + 1;
                else begin
                    m_count[i] = (m_count[i] + 1) % m;
                    m_wrap[i]  = (m_count[i] == 0);
                end
            end else begin
                if (sat) m_count[i] = (m_count[i] == 0) ? 0 : m_count[i] - 1;
                else begin
                    m_count[i] = (m_count[i] + m - 1) % m;
                    m_wrap[i]  = (m_count[i] == m - 1);
                end
            end
        end
    endtask

    function automatic bit model_tc(input int i);
        return mode ? (m_count[i] == 0) : (m_count[i] == m_mod[i] - 1);
    endfunction

    task automatic compare_all(input string tag);
        check({tag, " a.data_out"}, bus_a.data_out, m_count[0]);
        check({tag, " a.wrap"}, bus_a.wrap, m_wrap[0]);
        check({tag, " a.load_err"}, bus_a.load_err, m_err[0]);
        check({tag, " a.tc"}, bus_a.tc, model_tc(0));
        check({tag, " b.data_out"}, bus_b.data_out, m_count[1]);
        check({tag, " b.wrap"}, bus_b.wrap, m_wrap[1]);
        check({tag, " b.load_err"}, bus_b.load_err, m_err[1]);
        check({tag, " b.tc"}, bus_b.tc, model_tc(1));
    endtask

    task automatic cycle(input string tag);
        @(posedge clock);
        model_step(0);
        model_step(1);
        #1;
        compare_all(tag);
    endtask

    initial begin
        reset   = 1'b1;
        enable  = 1'b0;
        load    = 1'b0;
        mode    = 1'b0;
        sat     = 1'b0;
        data_in = '0;
        mod_we  = 1'b0;
        mod_in  = '0;
        model_reset();

        #1;
        compare_all("reset");
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Count to 7, then reset asynchronously between edges.
        enable = 1'b1;
        repeat (7) cycle("count_to_7");
        check("pre-reset a.data_out", bus_a.data_out, 7);
        #2 reset = 1'b1;
        #1;
        check("async reset a.data_out", bus_a.data_out, 0);
        check("async reset b.data_out", bus_b.data_out, 3);
        model_reset();
        #2 reset = 1'b0;
        repeat (12) cycle("wrap_up");
        check("wrap_up final a.data_out", bus_a.data_out, 0);
        check("wrap_up final a.wrap", bus_a.wrap, 1);

        // Vectors for dut_a; expectations after each edge.
        vecs.push_back('{0, 1, 1, 0, 2,  2,  0, 0, 0});
        vecs.push_back('{1, 0, 1, 0, 0,  1,  0, 0, 0});
        vecs.push_back('{1, 0, 1, 0, 0,  0,  0, 0, 1});
        vecs.push_back('{1, 0, 1, 0, 0,  11, 1, 0, 0});
        vecs.push_back('{1, 0, 1, 0, 0,  10, 0, 0, 0});
        vecs.push_back('{0, 1, 0, 1, 9,  9,  0, 0, 0});
        vecs.push_back('{1, 0, 0, 1, 0,  10, 0, 0, 0});
        repeat (4) vecs.push_back('{1, 0, 0, 1, 0, 11, 0, 0, 1});
        vecs.push_back('{0, 1, 1, 1, 1,  1,  0, 0, 0});
        repeat (3) vecs.push_back('{1, 0, 1, 1, 0, 0, 0, 0, 1});
        vecs.push_back('{1, 1, 0, 0, 5,  5,  0, 0, 0});
        vecs.push_back('{1, 1, 0, 0, 14, 11, 0, 1, 1});
        vecs.push_back('{0, 0, 0, 0, 0,  11, 0, 0, 1});
        vecs.push_back('{0, 1, 0, 0, 15, 11, 0, 1, 1});
        vecs.push_back('{1, 1, 0, 0, 12, 11, 0, 1, 1});
        vecs.push_back('{0, 0, 0, 0, 0,  11, 0, 0, 1});
        vecs.push_back('{0, 1, 0, 0, 0,  0,  0, 0, 0});
        repeat (4) vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0});

        foreach (vecs[k]) begin
            enable  = vecs[k].en;
            load    = vecs[k].ld;
            mode    = vecs[k].md;
            sat     = vecs[k].st;
            data_in = 4'(vecs[k].din);
            cycle("vec");
            check($sformatf("vec%0d data_out", k), bus_a.data_out, vecs[k].out);
            check($sformatf("vec%0d wrap", k), bus_a.wrap, vecs[k].wr);
            check($sformatf("vec%0d load_err", k), bus_a.load_err, vecs[k].er);
            check($sformatf("vec%0d tc", k), bus_a.tc, vecs[k].tcx);
        end

        // tc follows mode without a clock edge.
        mode = 1'b1;
        #1;
        check("mode flip tc", bus_a.tc, 1);
        check("mode flip data_out", bus_a.data_out, 0);
        cycle("hold_down");

`ifdef UPDOWN_MODN_PROG_MOD_EN
        enable  = 1'b0;
        load    = 1'b1;
        mode    = 1'b0;
        sat     = 1'b0;
        data_in = 4'd9;
        cycle("prog load");
        load   = 1'b0;
        enable = 1'b1;
        mod_we = 1'b1;
        mod_in = 5'd6;
        cycle("prog write");
        check("prog clamp a.data_out", bus_a.data_out, 5);
        mod_we = 1'b0;
        repeat (6) cycle("prog count");
        check("prog count a.data_out", bus_a.data_out, 5);
        cycle("prog wrap");
        check("prog wrap a.data_out", bus_a.data_out, 0);
        check("prog wrap a.wrap", bus_a.wrap, 1);
        mod_we = 1'b1;
        mod_in = 5'd1;
        cycle("prog bad");
        check("prog bad a.load_err", bus_a.load_err, 1);
        mod_in = 5'd12;
        cycle("prog restore");
        mod_we = 1'b0;
`endif

        for (int n = 0; n < 3000; n++) begin
            enable  = ($urandom_range(0, 3) != 0);
            load    = ($urandom_range(0, 15) == 0);
            mode    = $urandom_range(0, 1) == 1;
            sat     = ($urandom_range(0, 3) == 0);
            data_in = 4'($urandom_range(0, 15));
`ifdef UPDOWN_MODN_PROG_MOD_EN
            mod_we  = ($urandom_range(0, 31) == 0);
            mod_in  = 5'($urandom_range(0, 17));
`endif
            cycle("random");
            if ($urandom_range(0, 199) == 0) begin
                #2 reset = 1'b1;
                #1;
                check("random reset a.data_out", bus_a.data_out, 0);
                check("random reset b.data_out", bus_b.data_out, 3);
                model_reset();
                #1 reset = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
